dfu_alt_router: RTL and testbench

DFU_ALT_ROUTER -- requirements
Module: dfu_alt_router

---
 rtl/dfu_pkg.sv | 33 +++
 rtl/wait_gate.sv | 45 ++++
 rtl/dfu_alt_router.sv | 205 ++++++++++++++++++++
 tb/tb_dfu_alt_router.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dfu_pkg.sv
// Shared DFU definitions: DFU 1.1 bStatus codes and the alt-router FSM encoding.
package dfu_pkg;

    typedef enum logic [3:0] {
        DFU_OK               = 4'h0,
        DFU_ERR_TARGET       = 4'h1,
        DFU_ERR_FILE         = 4'h2,
        DFU_ERR_WRITE        = 4'h3,
        DFU_ERR_ERASE        = 4'h4,
        DFU_ERR_CHECK_ERASED = 4'h5,
        DFU_ERR_PROG         = 4'h6,
        DFU_ERR_VERIFY       = 4'h7,
        DFU_ERR_ADDRESS      = 4'h8,
        DFU_ERR_NOTDONE      = 4'h9,
        DFU_ERR_FIRMWARE     = 4'hA,
        DFU_ERR_VENDOR       = 4'hB,
        DFU_ERR_USBR         = 4'hC,
        DFU_ERR_POR          = 4'hD,
        DFU_ERR_UNKNOWN      = 4'hE,
        DFU_ERR_STALLEDPKT   = 4'hF
    } dfu_status_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RAM_S   = 3'd1,
        FLASH_S = 3'd2,
        DRAIN   = 3'd3,
        ERR     = 3'd4
    } router_state_t;

    localparam int unsigned WAIT_W = 8;

endpackage

// File: rtl/wait_gate.sv
// Wait-state counter for the RAM target: after every accepted byte the
// handshakes in both directions are masked for WAIT_CYCLES clocks.
module wait_gate
    import dfu_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 10
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic active,
    input  logic host_out_valid,
    input  logic tgt_out_ready,
    input  logic tgt_in_valid,
    input  logic host_in_ready,
    output logic tgt_out_valid,
    output logic host_out_ready,
    output logic host_in_valid,
    output logic tgt_in_ready
);

    logic [WAIT_W-1:0] cnt_q;
    logic              gate_open;
    logic              accept;

    assign gate_open      = active && (cnt_q == '0);
    assign tgt_out_valid  = gate_open && host_out_valid;
    assign host_out_ready = gate_open && tgt_out_ready;
    assign host_in_valid  = gate_open && tgt_in_valid;
    assign tgt_in_ready   = gate_open && host_in_ready;
    assign accept         = (tgt_out_valid && host_out_ready) || (host_in_valid && tgt_in_ready);

    // A stale count is dropped between sessions so a new session starts unthrottled.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
        end else if (!active) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= WAIT_W'(WAIT_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - WAIT_W'(1);
        end
    end

endmodule

// File: rtl/dfu_alt_router.sv
// DFU alt-setting router: steers host download/upload byte streams to a RAM or flash target.
// Define DFU_ALT_ROUTER_ALT_CHECK_EN to trap out-of-range alts in an error state (errTARGET).
module dfu_alt_router
    import dfu_pkg::*;
#(
    parameter int unsigned              N_ALT       = 4,
    parameter int unsigned              RAM_AW      = 10,
    parameter int unsigned              WAIT_CYCLES = 10,
    parameter logic [N_ALT-1:0]         ALT_FLASH   = 4'b1000,
    parameter logic [N_ALT*RAM_AW-1:0]  ALT_RAM_END = {10'd64, 10'd64, 10'd63, 10'd14}
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [2:0]        dfu_alt_i,
    input  logic              dfu_out_en_i,
    input  logic              dfu_in_en_i,
    input  logic [7:0]        dfu_out_data_i,
    input  logic              dfu_out_valid_i,
    output logic              dfu_out_ready_o,
    output logic [7:0]        dfu_in_data_o,
    output logic              dfu_in_valid_o,
    input  logic              dfu_in_ready_i,
    input  logic              dfu_clear_status_i,
    output logic [3:0]        dfu_status_o,
    output logic              dfu_busy_o,
    output logic              ram_en_o,
    output logic [RAM_AW-1:0] ram_end_addr_o,
    output logic              ram_out_valid_o,
    input  logic              ram_out_ready_i,
    input  logic              ram_in_valid_i,
    output logic              ram_in_ready_o,
    input  logic [7:0]        ram_in_data_i,
    output logic              ram_clear_status_o,
    input  logic [3:0]        ram_status_i,
    output logic              flash_out_en_o,
    output logic              flash_in_en_o,
    output logic              flash_out_valid_o,
    input  logic              flash_out_ready_i,
    input  logic              flash_in_valid_i,
    output logic              flash_in_ready_o,
    input  logic [7:0]        flash_in_data_i,
    output logic              flash_clear_status_o,
    input  logic [3:0]        flash_status_i,
    input  logic              flash_busy_i,
    input  logic              flash_pending_i,
    output logic              rstn_o
);

    // Alt maps widened to the full 3-bit alt space; unused alts read as RAM with end address 0.
    localparam logic [7:0] FLASH_MAP = 8'(ALT_FLASH);

    logic [RAM_AW-1:0] end_tab [8];

    for (genvar i = 0; i < 8; i++) begin : g_end_tab
        if (i < N_ALT) begin : g_used
            assign end_tab[i] = ALT_RAM_END[i*RAM_AW +: RAM_AW];
        end else begin : g_unused
            assign end_tab[i] = '0;
        end
    end

    logic [1:0] sync_q;

    // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign rstn_o = sync_q[1];

    router_state_t state_q;
    logic [2:0]    alt_q;
    logic          sess_en;
    logic          sel_flash;
    logic          err_q;

    assign sess_en   = dfu_out_en_i | dfu_in_en_i;
    assign sel_flash = FLASH_MAP[alt_q];

`ifdef DFU_ALT_ROUTER_ALT_CHECK_EN
    localparam logic [7:0] ALT_VALID = 8'((1 << N_ALT) - 1);

    logic err_set;

    assign err_set = (state_q == IDLE) && sess_en && !ALT_VALID[dfu_alt_i];

    // Setting has priority so an error raised in the same cycle as a clear is not lost.
    always_ff @(posedge clk_i or negedge rstn_o) begin
        if (!rstn_o) begin
            err_q <= 1'b0;
        end else if (err_set) begin
            err_q <= 1'b1;
        end else if (dfu_clear_status_i) begin
            err_q <= 1'b0;
        end
    end
`else
    assign err_q = 1'b0;
`endif

    // IDLE starts on enable level, so a session requested during DRAIN begins once draining ends.
    always_ff @(posedge clk_i or negedge rstn_o) begin
        if (!rstn_o) begin
            state_q <= IDLE;
            alt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sess_en) begin
                        alt_q <= dfu_alt_i;
`ifdef DFU_ALT_ROUTER_ALT_CHECK_EN
                        if (!ALT_VALID[dfu_alt_i]) begin
                            state_q <= ERR;
                        end else
`endif
                        if (FLASH_MAP[dfu_alt_i]) begin
                            state_q <= FLASH_S;
                        end else begin
                            state_q <= RAM_S;
                        end
                    end
                end
                RAM_S: begin
                    if (!sess_en) state_q <= IDLE;
                end
                FLASH_S: begin
                    if (!sess_en) state_q <= flash_pending_i ? DRAIN : IDLE;
                end
                DRAIN: begin
                    if (!flash_pending_i) state_q <= IDLE;
                end
`ifdef DFU_ALT_ROUTER_ALT_CHECK_EN
                ERR: begin
                    if (!sess_en) state_q <= IDLE;
                end
`endif
                default: state_q <= IDLE;
            endcase
        end
    end

    logic ram_host_out_ready;
    logic ram_host_in_valid;

    wait_gate #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_wait_gate (
        .clk_i          (clk_i),
        .rstn_i         (rstn_o),
        .active         (state_q == RAM_S),
        .host_out_valid (dfu_out_valid_i),
        .tgt_out_ready  (ram_out_ready_i),
        .tgt_in_valid   (ram_in_valid_i),
        .host_in_ready  (dfu_in_ready_i),
        .tgt_out_valid  (ram_out_valid_o),
        .host_out_ready (ram_host_out_ready),
        .host_in_valid  (ram_host_in_valid),
        .tgt_in_ready   (ram_in_ready_o)
    );

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        ram_en_o          = 1'b0;
        ram_end_addr_o    = '0;
        flash_out_en_o    = 1'b0;
        flash_in_en_o     = 1'b0;
        flash_out_valid_o = 1'b0;
        flash_in_ready_o  = 1'b0;
        dfu_out_ready_o   = 1'b0;
        dfu_in_valid_o    = 1'b0;
        dfu_busy_o        = 1'b0;
        case (state_q)
            RAM_S: begin
                ram_en_o        = 1'b1;
                ram_end_addr_o  = end_tab[alt_q];
                dfu_out_ready_o = ram_host_out_ready;
                dfu_in_valid_o  = ram_host_in_valid;
            end
            FLASH_S: begin
                flash_out_en_o    = dfu_out_en_i;
                flash_in_en_o     = dfu_in_en_i;
                flash_out_valid_o = dfu_out_valid_i;
                flash_in_ready_o  = dfu_in_ready_i;
                dfu_out_ready_o   = flash_out_ready_i;
                dfu_in_valid_o    = flash_in_valid_i;
                dfu_busy_o        = flash_busy_i;
            end
            DRAIN: begin
                flash_out_en_o = 1'b1;
                dfu_busy_o     = 1'b1;
            end
            default: ;
        endcase
    end

    assign dfu_in_data_o        = sel_flash ? flash_in_data_i : ram_in_data_i;
    assign dfu_status_o         = err_q ? 4'(DFU_ERR_TARGET) : (sel_flash ? flash_status_i : ram_status_i);
    assign ram_clear_status_o   = dfu_clear_status_i & ~sel_flash;
    assign flash_clear_status_o = dfu_clear_status_i & sel_flash;

endmodule

// File: tb/tb_dfu_alt_router.sv
// Self-checking bench for dfu_alt_router: routing vector table plus multi-cycle
// sequences for RAM wait states, flash drain, alt latching, reset and alt errors.
module tb_dfu_alt_router;

    logic       clk_i = 1'b0;
    logic       rstn_i;
    logic [2:0] dfu_alt_i;
    logic       dfu_out_en_i, dfu_in_en_i;
    logic [7:0] dfu_out_data_i;
    logic       dfu_out_valid_i, dfu_out_ready_o;
    logic [7:0] dfu_in_data_o;
    logic       dfu_in_valid_o, dfu_in_ready_i;
    logic       dfu_clear_status_i;
    logic [3:0] dfu_status_o;
    logic       dfu_busy_o;
    logic       ram_en_o;
    logic [9:0] ram_end_addr_o;
    logic       ram_out_valid_o, ram_out_ready_i, ram_in_valid_i, ram_in_ready_o;
    logic [7:0] ram_in_data_i;
    logic       ram_clear_status_o;
    logic [3:0] ram_status_i;
    logic       flash_out_en_o, flash_in_en_o, flash_out_valid_o, flash_out_ready_i;
    logic       flash_in_valid_i, flash_in_ready_o;
    logic [7:0] flash_in_data_i;
    logic       flash_clear_status_o;
    logic [3:0] flash_status_i;
    logic       flash_busy_i, flash_pending_i;
    logic       rstn_o;

    always #5 clk_i = ~clk_i;

    dfu_alt_router dut (
        .clk_i                (clk_i),
        .rstn_i               (rstn_i),
        .dfu_alt_i            (dfu_alt_i),
        .dfu_out_en_i         (dfu_out_en_i),
        .dfu_in_en_i          (dfu_in_en_i),
        .dfu_out_data_i       (dfu_out_data_i),
        .dfu_out_valid_i      (dfu_out_valid_i),
        .dfu_out_ready_o      (dfu_out_ready_o),
        .dfu_in_data_o        (dfu_in_data_o),
        .dfu_in_valid_o       (dfu_in_valid_o),
        .dfu_in_ready_i       (dfu_in_ready_i),
        .dfu_clear_status_i   (dfu_clear_status_i),
        .dfu_status_o         (dfu_status_o),
        .dfu_busy_o           (dfu_busy_o),
        .ram_en_o             (ram_en_o),
        .ram_end_addr_o       (ram_end_addr_o),
        .ram_out_valid_o      (ram_out_valid_o),
        .ram_out_ready_i      (ram_out_ready_i),
        .ram_in_valid_i       (ram_in_valid_i),
        .ram_in_ready_o       (ram_in_ready_o),
        .ram_in_data_i        (ram_in_data_i),
        .ram_clear_status_o   (ram_clear_status_o),
        .ram_status_i         (ram_status_i),
        .flash_out_en_o       (flash_out_en_o),
        .flash_in_en_o        (flash_in_en_o),
        .flash_out_valid_o    (flash_out_valid_o),
        .flash_out_ready_i    (flash_out_ready_i),
        .flash_in_valid_i     (flash_in_valid_i),
        .flash_in_ready_o     (flash_in_ready_o),
        .flash_in_data_i      (flash_in_data_i),
        .flash_clear_status_o (flash_clear_status_o),
        .flash_status_i       (flash_status_i),
        .flash_busy_i         (flash_busy_i),
        .flash_pending_i      (flash_pending_i),
        .rstn_o               (rstn_o)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        dfu_out_en_i       = 1'b0;
        dfu_in_en_i        = 1'b0;
        dfu_out_valid_i    = 1'b0;
        dfu_in_ready_i     = 1'b0;
        dfu_clear_status_i = 1'b0;
        ram_out_ready_i    = 1'b0;
        ram_in_valid_i     = 1'b0;
        ram_in_data_i      = 8'h00;
        flash_out_ready_i  = 1'b0;
        flash_in_valid_i   = 1'b0;
        flash_in_data_i    = 8'h00;
        flash_busy_i       = 1'b0;
    endtask

    // Fields: inputs alt..fb, then expected ram_en, flash_out_en, out_ready, ram_out_valid,
    // flash_out_valid, busy, end_addr, status.
    typedef struct {
        logic [2:0] alt;
        logic [3:0] ram_st, fl_st;
        logic       ov, rr, fr, fb;
        logic       x_ram_en, x_fo_en, x_ready, x_rov, x_fov, x_busy;
        logic [9:0] x_end;
        logic [3:0] x_status;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int last;
        int nbytes;
        int ok_cnt;

        vecs[0] = '{3'd0, 4'h2, 4'h5, 1, 1, 0, 1, 1, 0, 1, 1, 0, 0, 10'd14, 4'h2};
        vecs[1] = '{3'd1, 4'h3, 4'h6, 0, 1, 1, 1, 1, 0, 1, 0, 0, 0, 10'd63, 4'h3};
        vecs[2] = '{3'd2, 4'h0, 4'h7, 1, 0, 1, 0, 1, 0, 0, 1, 0, 0, 10'd64, 4'h0};
        vecs[3] = '{3'd3, 4'h4, 4'h9, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1, 10'd0,  4'h9};
        vecs[4] = '{3'd3, 4'h4, 4'h0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 10'd0,  4'h0};

        rstn_i          = 1'b1;
        dfu_alt_i       = 3'd0;
        dfu_out_data_i  = 8'h00;
        flash_pending_i = 1'b0;
        ram_status_i    = 4'h6;
        flash_status_i  = 4'h0;
        idle_inputs();
        #2 rstn_i = 1'b0;
        step();
        step();

        // Reset state
        check("rst_rstn_o", rstn_o, 0);
        check("rst_ram_en", ram_en_o, 0);
        check("rst_flash_out_en", flash_out_en_o, 0);
        check("rst_busy", dfu_busy_o, 0);
        check("rst_status", dfu_status_o, 4'h6);
        rstn_i = 1'b1;
        step();
        check("rst_sync_edge1", rstn_o, 0);
        step();
        check("rst_sync_edge2", rstn_o, 1);
        ram_status_i = 4'h0;

        // Routing vector table
        for (int i = 0; i < 5; i++) begin
            dfu_alt_i      = vecs[i].alt;
            ram_status_i   = vecs[i].ram_st;
            flash_status_i = vecs[i].fl_st;
            flash_busy_i   = vecs[i].fb;
            dfu_out_en_i   = 1'b1;
            step();
            dfu_out_valid_i   = vecs[i].ov;
            ram_out_ready_i   = vecs[i].rr;
            flash_out_ready_i = vecs[i].fr;
            #1;
            check($sformatf("v%0d_ram_en", i), ram_en_o, vecs[i].x_ram_en);
            check($sformatf("v%0d_flash_out_en", i), flash_out_en_o, vecs[i].x_fo_en);
            check($sformatf("v%0d_out_ready", i), dfu_out_ready_o, vecs[i].x_ready);
            check($sformatf("v%0d_ram_out_valid", i), ram_out_valid_o, vecs[i].x_rov);
            check($sformatf("v%0d_flash_out_valid", i), flash_out_valid_o, vecs[i].x_fov);
            check($sformatf("v%0d_busy", i), dfu_busy_o, vecs[i].x_busy);
            check($sformatf("v%0d_end_addr", i), ram_end_addr_o, vecs[i].x_end);
            check($sformatf("v%0d_status", i), dfu_status_o, vecs[i].x_status);
            idle_inputs();
            step();
            step();
        end
        ram_status_i   = 4'h0;
        flash_status_i = 4'h0;

        // Flash upload passthrough and clear forwarding
        dfu_alt_i   = 3'd3;
        dfu_in_en_i = 1'b1;
        step();
        flash_in_valid_i   = 1'b1;
        flash_in_data_i    = 8'hA5;
        dfu_in_ready_i     = 1'b1;
        dfu_clear_status_i = 1'b1;
        #1;
        check("fup_in_valid", dfu_in_valid_o, 1);
        check("fup_in_data", dfu_in_data_o, 8'hA5);
        check("fup_flash_in_ready", flash_in_ready_o, 1);
        check("fup_flash_in_en", flash_in_en_o, 1);
        check("fup_flash_out_en", flash_out_en_o, 0);
        check("fup_flash_clear", flash_clear_status_o, 1);
        check("fup_ram_clear", ram_clear_status_o, 0);
        idle_inputs();
        step();
        step();

        // RAM upload: one byte, then masked during wait states
        dfu_alt_i   = 3'd0;
        dfu_in_en_i = 1'b1;
        step();
        ram_in_valid_i = 1'b1;
        ram_in_data_i  = 8'h3C;
        dfu_in_ready_i = 1'b1;
        #1;
        check("rup_in_valid", dfu_in_valid_o, 1);
        check("rup_in_data", dfu_in_data_o, 8'h3C);
        check("rup_ram_in_ready", ram_in_ready_o, 1);
        step();
        check("rup_wait_in_valid", dfu_in_valid_o, 0);
        check("rup_wait_ram_in_ready", ram_in_ready_o, 0);
        idle_inputs();
        step();
        step();

        // 15-byte RAM download on alt 0: one byte every WAIT_CYCLES+1 = 11 cycles
        dfu_alt_i    = 3'd0;
        dfu_out_en_i = 1'b1;
        step();
        dfu_out_valid_i = 1'b1;
        ram_out_ready_i = 1'b1;
        check("dl_end_addr", ram_end_addr_o, 10'd14);
        last   = -1;
        nbytes = 0;
        for (int c = 0; c < 15 * 11 + 20 && nbytes < 15; c++) begin
            #1;
            if (dfu_out_ready_o && ram_out_valid_o) begin
                if (last >= 0) check($sformatf("dl_gap%0d", nbytes), c - last, 11);
                last = c;
                nbytes++;
            end
            step();
        end
        check("dl_byte_count", nbytes, 15);
        idle_inputs();
        step();
        step();

        // Alt change mid RAM session is ignored
        dfu_alt_i      = 3'd1;
        ram_status_i   = 4'h5;
        flash_status_i = 4'h9;
        dfu_out_en_i   = 1'b1;
        step();
        check("alt_hold_end_first", ram_end_addr_o, 10'd63);
        dfu_alt_i = 3'd3;
        step();
        step();
        check("alt_hold_end", ram_end_addr_o, 10'd63);
        check("alt_hold_ram_en", ram_en_o, 1);
        check("alt_hold_flash_out_en", flash_out_en_o, 0);
        check("alt_hold_status", dfu_status_o, 4'h5);
        idle_inputs();
        ram_status_i   = 4'h0;
        flash_status_i = 4'h0;
        step();
        step();

        // Flash drain for 50 cycles, with a new session queued during the drain
        dfu_alt_i    = 3'd3;
        dfu_out_en_i = 1'b1;
        step();
        flash_pending_i = 1'b1;
        dfu_out_en_i    = 1'b0;
        step();
        dfu_out_valid_i   = 1'b1;
        flash_out_ready_i = 1'b1;
        ok_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (dfu_busy_o && flash_out_en_o && !dfu_out_ready_o && !flash_out_valid_o && !ram_en_o)
                ok_cnt++;
            if (i == 20) begin
                dfu_alt_i    = 3'd0;
                dfu_out_en_i = 1'b1;
            end
            if (i == 49) flash_pending_i = 1'b0;
            step();
        end
        check("drain_cycles", ok_cnt, 50);
        check("drain_exit_busy", dfu_busy_o, 0);
        check("drain_exit_flash_out_en", flash_out_en_o, 0);
        check("drain_exit_ram_en", ram_en_o, 0);
        step();
        check("drain_queued_ram_en", ram_en_o, 1);
        check("drain_queued_end", ram_end_addr_o, 10'd14);
        idle_inputs();
        step();
        step();

        // Reset asserted during DRAIN
        dfu_alt_i    = 3'd3;
        dfu_out_en_i = 1'b1;
        step();
        flash_pending_i = 1'b1;
        dfu_out_en_i    = 1'b0;
        step();
        check("rdrain_busy_before", dfu_busy_o, 1);
        rstn_i = 1'b0;
        #1;
        check("rdrain_busy", dfu_busy_o, 0);
        check("rdrain_flash_out_en", flash_out_en_o, 0);
        check("rdrain_rstn_o", rstn_o, 0);
        step();
        rstn_i = 1'b1;
        step();
        check("rdrain_rstn_o_edge1", rstn_o, 0);
        step();
        check("rdrain_rstn_o_edge2", rstn_o, 1);
        check("rdrain_idle_busy", dfu_busy_o, 0);
        check("rdrain_idle_flash_out_en", flash_out_en_o, 0);
        flash_pending_i = 1'b0;
        step();

`ifdef DFU_ALT_ROUTER_ALT_CHECK_EN
        // Out-of-range alt traps in the error state
        ram_out_ready_i   = 1'b1;
        flash_out_ready_i = 1'b1;
        dfu_out_valid_i   = 1'b1;
        dfu_alt_i         = 3'd5;
        dfu_out_en_i      = 1'b1;
        step();
        check("err_status", dfu_status_o, 4'h1);
        check("err_out_ready", dfu_out_ready_o, 0);
        check("err_ram_en", ram_en_o, 0);
        dfu_clear_status_i = 1'b1;
        step();
        dfu_clear_status_i = 1'b0;
        #1;
        check("err_cleared", dfu_status_o, 4'h0);
        dfu_out_en_i = 1'b0;
        step();
        dfu_alt_i          = 3'd6;
        dfu_out_en_i       = 1'b1;
        dfu_clear_status_i = 1'b1;
        step();
        dfu_clear_status_i = 1'b0;
        #1;
        check("err_wins_over_clear", dfu_status_o, 4'h1);
        dfu_out_en_i = 1'b0;
        step();
        step();
        check("err_sticky_idle", dfu_status_o, 4'h1);
        dfu_clear_status_i = 1'b1;
        step();
        dfu_clear_status_i = 1'b0;
        #1;
        check("err_sticky_cleared", dfu_status_o, 4'h0);
        idle_inputs();
        step();
`else
        // Out-of-range alt falls back to RAM with end address 0
        dfu_alt_i    = 3'd5;
        ram_status_i = 4'h7;
        dfu_out_en_i = 1'b1;
        step();
        check("oor_ram_en", ram_en_o, 1);
        check("oor_end_addr", ram_end_addr_o, 10'd0);
        check("oor_status", dfu_status_o, 4'h7);
        check("oor_flash_out_en", flash_out_en_o, 0);
        idle_inputs();
        ram_status_i = 4'h0;
        step();
        step();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
